// File: rtl/tug_pkg.sv
// Shared types and sizing helpers for the tug-of-war scorer.
package tug_pkg;

    typedef enum logic [2:0] {
        PLAY    = 3'd0,
        WIN_L   = 3'd1,
        WIN_R   = 3'd2,
        MATCH_L = 3'd3,
        MATCH_R = 3'd4
    } tug_state_t;

    localparam int TALLY_W = 4;
    // Wide enough for -16..+16, i.e. one step past the largest legal HALF.
    localparam int POS_W   = 6;

    function automatic int score_width(input int half);
        return 2 * half + 1;
    endfunction

endpackage

// File: rtl/tug_score_dec.sv
// Combinational decode of rope position and game state onto the LED bar.
module tug_score_dec
    import tug_pkg::*;
#(
    parameter int HALF = 3
) (
    input  logic signed [POS_W-1:0]      pos,
    input  tug_state_t                   state,
    output logic [score_width(HALF)-1:0] score
);

    localparam int SW = score_width(HALF);

    logic [POS_W-1:0] idx;

    always_comb begin
        idx   = POS_W'(HALF) - $unsigned(pos);
        score = '0;
        case (state)
            PLAY: begin
                for (int i = 0; i < SW; i++) score[i] = (idx == POS_W'(i));
            end
            WIN_L, MATCH_L: begin
                for (int i = 0; i < SW; i++) score[i] = (i > HALF);
            end
            WIN_R, MATCH_R: begin
                for (int i = 0; i < SW; i++) score[i] = (i < HALF);
            end
            default: begin
                // Illegal encoding: 1010... from the MSB makes it obvious on the bar.
                for (int i = 0; i < SW; i++) score[i] = (((SW - 1 - i) % 2) == 0);
            end
        endcase
    end

endmodule

// File: rtl/tug_scorer.sv
// Tug-of-war scorer: rope position, game/match FSM and per-player game tallies.
module tug_scorer
    import tug_pkg::*;
#(
    parameter int HALF         = 3,
    parameter int GAMES_TO_WIN = 2,
    parameter int FAVOUR_LOSER = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         winrnd,
    input  logic                         right,
    input  logic                         leds_on,
    input  logic                         tie,
    input  logic                         newgame,
    output logic [score_width(HALF)-1:0] score,
    output logic                         game_over,
    output logic                         match_over,
    output logic [TALLY_W-1:0]           left_games,
    output logic [TALLY_W-1:0]           right_games
);

    if (HALF < 2 || HALF > 15) begin : g_bad_half
        $fatal(1, "tug_scorer: HALF must be in 2..15");
    end
    if (GAMES_TO_WIN < 1 || GAMES_TO_WIN > 15) begin : g_bad_games
        $fatal(1, "tug_scorer: GAMES_TO_WIN must be in 1..15");
    end
    if (FAVOUR_LOSER < 0 || FAVOUR_LOSER > 1) begin : g_bad_favour
        $fatal(1, "tug_scorer: FAVOUR_LOSER must be 0 or 1");
    end

    localparam logic signed [POS_W-1:0] P_MAX = POS_W'(HALF);
    localparam logic signed [POS_W-1:0] P_MIN = -P_MAX;
    localparam logic [TALLY_W-1:0]      G_WIN = TALLY_W'(GAMES_TO_WIN);
    localparam bit                      FAVOUR = (FAVOUR_LOSER != 0);

    tug_state_t                state, state_nxt;
    logic signed [POS_W-1:0]   pos, pos_nxt, step, target;
    logic [TALLY_W-1:0]        left_nxt, right_nxt, left_inc, right_inc;
    logic                      mr, two_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PLAY;
            pos         <= '0;
            left_games  <= '0;
            right_games <= '0;
        end else begin
            state       <= state_nxt;
            pos         <= pos_nxt;
            left_games  <= left_nxt;
            right_games <= right_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        left_nxt  = left_games;
        right_nxt = right_games;

        // A jumped-light push by the left player counts as a right move.
        mr       = (right & leds_on) | (~right & ~leds_on);
        two_step = FAVOUR & leds_on & (((pos == P_MAX) & ~mr) | ((pos == P_MIN) & mr));
        step     = two_step ? POS_W'(2) : POS_W'(1);
        target   = mr ? (pos + step) : (pos - step);

        left_inc  = (left_games  < G_WIN) ? left_games  + TALLY_W'(1) : left_games;
        right_inc = (right_games < G_WIN) ? right_games + TALLY_W'(1) : right_games;

        case (state)
            PLAY: begin
                if (winrnd && !tie) begin
                    if (target > P_MAX) begin
                        right_nxt = right_inc;
                        state_nxt = (right_inc == G_WIN) ? MATCH_R : WIN_R;
                    end else if (target < P_MIN) begin
                        left_nxt  = left_inc;
                        state_nxt = (left_inc == G_WIN) ? MATCH_L : WIN_L;
                    end else begin
                        pos_nxt = target;
                    end
                end
            end
            WIN_L, WIN_R: begin
                if (newgame) begin
                    state_nxt = PLAY;
                    pos_nxt   = '0;
                end
            end
            MATCH_L, MATCH_R: begin
            end
            default: begin
                state_nxt = PLAY;
                pos_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        game_over  = (state == WIN_L) || (state == WIN_R) ||
                     (state == MATCH_L) || (state == MATCH_R);
        match_over = (state == MATCH_L) || (state == MATCH_R);
    end

    tug_score_dec #(.HALF(HALF)) u_dec (
        .pos   (pos),
        .state (state),
        .score (score)
    );

endmodule

// File: tb/tb_tug_scorer.sv
// Directed bench for tug_scorer: vector table on the default build, hand sequences for HALF=5.
module tb_tug_scorer;
    import tug_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default build: HALF=3, GAMES_TO_WIN=2, FAVOUR_LOSER=1
    logic       rst, winrnd, right, leds_on, tie, newgame;
    logic [6:0] score;
    logic       game_over, match_over;
    logic [3:0] left_games, right_games;

    tug_scorer u0 (
        .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .leds_on(leds_on),
        .tie(tie), .newgame(newgame), .score(score), .game_over(game_over),
        .match_over(match_over), .left_games(left_games), .right_games(right_games)
    );

    // HALF=5, FAVOUR_LOSER=0
    logic        b_rst, b_winrnd, b_right, b_leds_on, b_tie, b_newgame;
    logic [10:0] b_score;
    logic        b_game_over, b_match_over;
    logic [3:0]  b_left_games, b_right_games;

    tug_scorer #(.HALF(5), .GAMES_TO_WIN(2), .FAVOUR_LOSER(0)) u1 (
        .clk(clk), .rst(b_rst), .winrnd(b_winrnd), .right(b_right), .leds_on(b_leds_on),
        .tie(b_tie), .newgame(b_newgame), .score(b_score), .game_over(b_game_over),
        .match_over(b_match_over), .left_games(b_left_games), .right_games(b_right_games)
    );

    // Stand-alone decoder to reach encodings the FSM never produces
    logic signed [POS_W-1:0] d_pos;
    tug_state_t              d_state;
    logic [6:0]              d_score;

    tug_score_dec #(.HALF(3)) u_dec (.pos(d_pos), .state(d_state), .score(d_score));

    typedef struct {
        logic       rst, w, r, l, t, n;
        logic [6:0] score;
        logic       go, mo;
        logic [3:0] lg, rg;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs[NV];

    function automatic vec_t mk(logic rs, logic w, logic r, logic l, logic t, logic n,
                                logic [6:0] sc, logic go, logic mo, logic [3:0] lg, logic [3:0] rg);
        vec_t v;
        v.rst = rs; v.w = w; v.r = r; v.l = l; v.t = t; v.n = n;
        v.score = sc; v.go = go; v.mo = mo; v.lg = lg; v.rg = rg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic b_step(input logic rs, input logic w, input logic r, input logic l);
        @(negedge clk);
        b_rst = rs; b_winrnd = w; b_right = r; b_leds_on = l;
        @(posedge clk);
        #1;
        b_rst = 1'b0; b_winrnd = 1'b0;
    endtask

    logic [10:0] b_exp;

    initial begin
        rst = 1'b1; winrnd = 1'b0; right = 1'b0; leds_on = 1'b0; tie = 1'b0; newgame = 1'b0;
        b_rst = 1'b1; b_winrnd = 1'b0; b_right = 1'b0; b_leds_on = 1'b0; b_tie = 1'b0; b_newgame = 1'b0;

        //               rst w  r  l  t  n   score       go mo lg rg
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 7'b0001000, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 1, 0, 0, 7'b0000100, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 1, 1, 0, 0, 7'b0000010, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 1, 1, 0, 0, 7'b0000001, 0, 0, 0, 0);
        vecs[4]  = mk(0, 1, 1, 1, 0, 0, 7'b0000111, 1, 0, 0, 1);
        vecs[5]  = mk(0, 1, 1, 1, 0, 1, 7'b0001000, 0, 0, 0, 1);
        vecs[6]  = mk(0, 1, 1, 1, 1, 0, 7'b0001000, 0, 0, 0, 1);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 7'b0000100, 0, 0, 0, 1);
        vecs[8]  = mk(0, 1, 0, 1, 0, 0, 7'b0001000, 0, 0, 0, 1);
        vecs[9]  = mk(0, 1, 0, 1, 0, 0, 7'b0010000, 0, 0, 0, 1);
        vecs[10] = mk(0, 1, 0, 1, 0, 0, 7'b0100000, 0, 0, 0, 1);
        vecs[11] = mk(0, 1, 0, 1, 0, 0, 7'b1000000, 0, 0, 0, 1);
        vecs[12] = mk(0, 1, 1, 1, 0, 0, 7'b0010000, 0, 0, 0, 1);
        vecs[13] = mk(0, 1, 0, 1, 0, 0, 7'b0100000, 0, 0, 0, 1);
        vecs[14] = mk(0, 1, 0, 1, 0, 0, 7'b1000000, 0, 0, 0, 1);
        vecs[15] = mk(0, 1, 0, 0, 0, 0, 7'b0100000, 0, 0, 0, 1);
        vecs[16] = mk(0, 0, 1, 1, 0, 0, 7'b0100000, 0, 0, 0, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 1, 7'b0100000, 0, 0, 0, 1);
        vecs[18] = mk(0, 1, 0, 1, 0, 0, 7'b1000000, 0, 0, 0, 1);
        vecs[19] = mk(0, 1, 0, 1, 0, 0, 7'b1110000, 1, 0, 1, 1);
        vecs[20] = mk(0, 1, 0, 1, 0, 0, 7'b1110000, 1, 0, 1, 1);
        vecs[21] = mk(0, 0, 0, 0, 0, 1, 7'b0001000, 0, 0, 1, 1);
        vecs[22] = mk(0, 1, 1, 1, 0, 0, 7'b0000100, 0, 0, 1, 1);
        vecs[23] = mk(0, 1, 1, 1, 0, 0, 7'b0000010, 0, 0, 1, 1);
        vecs[24] = mk(0, 1, 1, 1, 0, 0, 7'b0000001, 0, 0, 1, 1);
        vecs[25] = mk(0, 1, 0, 1, 0, 0, 7'b0000100, 0, 0, 1, 1);
        vecs[26] = mk(0, 1, 0, 1, 0, 0, 7'b0001000, 0, 0, 1, 1);
        vecs[27] = mk(0, 1, 0, 1, 0, 0, 7'b0010000, 0, 0, 1, 1);
        vecs[28] = mk(0, 1, 0, 1, 0, 0, 7'b0100000, 0, 0, 1, 1);
        vecs[29] = mk(0, 1, 0, 1, 0, 0, 7'b1000000, 0, 0, 1, 1);
        vecs[30] = mk(0, 1, 0, 1, 0, 0, 7'b1110000, 1, 1, 2, 1);
        vecs[31] = mk(0, 0, 0, 0, 0, 1, 7'b1110000, 1, 1, 2, 1);
        vecs[32] = mk(0, 1, 0, 1, 0, 0, 7'b1110000, 1, 1, 2, 1);
        vecs[33] = mk(1, 1, 1, 1, 0, 0, 7'b0001000, 0, 0, 0, 0);
        vecs[34] = mk(0, 1, 1, 1, 0, 0, 7'b0000100, 0, 0, 0, 0);
        vecs[35] = mk(1, 0, 0, 0, 0, 1, 7'b0001000, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; winrnd = vecs[i].w; right = vecs[i].r;
            leds_on = vecs[i].l; tie = vecs[i].t; newgame = vecs[i].n;
            @(posedge clk);
            #1;
            n_tests++;
            if ({score, game_over, match_over, left_games, right_games} !==
                {vecs[i].score, vecs[i].go, vecs[i].mo, vecs[i].lg, vecs[i].rg}) begin
                n_fail++;
                $display("FAIL vec%0d: got score=%b go=%b mo=%b lg=%0d rg=%0d expected score=%b go=%b mo=%b lg=%0d rg=%0d",
                         i, score, game_over, match_over, left_games, right_games,
                         vecs[i].score, vecs[i].go, vecs[i].mo, vecs[i].lg, vecs[i].rg);
            end
        end
        @(negedge clk);
        rst = 1'b0; winrnd = 1'b0; newgame = 1'b0;

        // HALF=5, no recovery boost: L5 -> L4 on a proper right push
        b_step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("h5_reset", 32'(b_score), 32'(11'b00000100000));
        for (int k = 1; k <= 5; k++) begin
            b_step(1'b0, 1'b1, 1'b0, 1'b1);
            b_exp = 11'd1 << (5 + k);
            chk($sformatf("h5_left%0d", k), 32'(b_score), 32'(b_exp));
        end
        b_step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("h5_l5_to_l4", 32'(b_score), 32'(11'b01000000000));

        // Six left moves from centre win the game for the left player
        b_step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("h5_reset2", 32'(b_score), 32'(11'b00000100000));
        for (int k = 1; k <= 6; k++) b_step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("h5_win_l", 32'({b_score, b_game_over, b_match_over, b_left_games}),
            32'({11'b11111000000, 1'b1, 1'b0, 4'd1}));

        // Decoder with an encoding the FSM never holds, plus a legal right-win decode
        d_pos = '0;
        d_state = tug_state_t'(3'd7);
        #1;
        chk("dec_illegal", 32'(d_score), 32'(7'b1010101));
        d_state = MATCH_R;
        #1;
        chk("dec_match_r", 32'(d_score), 32'(7'b0000111));
        d_state = PLAY;
        d_pos = -6'sd2;
        #1;
        chk("dec_play_l2", 32'(d_score), 32'(7'b0100000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tug_scorer.md
TUG_SCORER -- requirements
Module: tug_scorer

Interface
REQ-001 SHALL have parameter HALF, default 3: number of positions per side, excluding centre; legal range 2..15.
REQ-002 SHALL have parameter GAMES_TO_WIN, default 2: games a player must win to take the match; legal range 1..15.
REQ-003 SHALL have parameter FAVOUR_LOSER, default 1: enables the 2-step recovery rule in REQ-012.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-006 SHALL have ports winrnd (1-cycle pulse, a push occurred), right (right player pushed first), leds_on (lights were on at the push), tie (simultaneous push) and newgame (1-cycle pulse, start the next game); all inputs, 1 bit each.
REQ-007 SHALL have port score, output, 2*HALF+1 bits: bit HALF is centre; bit HALF+k is Lk; bit HALF-k is Rk.
REQ-008 SHALL have outputs game_over (1 bit), match_over (1 bit), left_games and right_games (4 bits each, game tallies).

Function
REQ-009 SHALL hold position pos, a signed value in -HALF..+HALF (negative is left), and FSM state in {PLAY, WIN_L, WIN_R, MATCH_L, MATCH_R}.
REQ-010 SHALL define mr = (right AND leds_on) OR (NOT right AND NOT leds_on): move right on a proper right push or a jumped-light left push.
REQ-011 In PLAY with winrnd=1 and tie=0, pos SHALL move one step toward the mr side on the next edge; winrnd=0 or tie=1 SHALL leave state unchanged.
REQ-012 With FAVOUR_LOSER=1 and leds_on=1, a move from pos=±HALF toward centre SHALL be two steps (L3->L1, R3->R1 for HALF=3); in all other cases the step is one.
REQ-013 A move beyond +HALF SHALL enter WIN_R and a move beyond -HALF SHALL enter WIN_L; on that edge the winner's tally increments by 1 and saturates at GAMES_TO_WIN.
REQ-014 If the incremented tally equals GAMES_TO_WIN, the FSM SHALL enter MATCH_R or MATCH_L instead of WIN_R or WIN_L.
REQ-015 In WIN_L or WIN_R, winrnd SHALL be ignored; newgame SHALL set pos=0 and state=PLAY on the next edge, and newgame takes priority over a coincident winrnd.
REQ-016 newgame SHALL be ignored in PLAY, MATCH_L and MATCH_R; MATCH states are left only by rst.
REQ-017 score SHALL be combinational from registered state: PLAY gives one-hot at bit HALF-pos; WIN_L/MATCH_L give bits 2*HALF..HALF+1 set and all others clear; WIN_R/MATCH_R give bits HALF-1..0 set and all others clear.
REQ-018 game_over SHALL be 1 in WIN_* and MATCH_*; match_over SHALL be 1 in MATCH_* only; both are decoded from registered state.
REQ-019 Latency SHALL be one cycle: a winrnd sampled at edge n is reflected on score after edge n.
REQ-020 An unreachable state encoding SHALL drive score to alternating 1010... from MSB and recover to PLAY with pos=0 on the next edge.

Reset
REQ-021 rst=1 at a clock edge SHALL set state=PLAY, pos=0, left_games=0 and right_games=0, overriding all other inputs, including mid-game and mid-match.
REQ-022 After reset: score has only bit HALF set; game_over=0; match_over=0.

Structure
REQ-023 State enum, score-width function and tally width SHALL live in shared package tug_pkg.
REQ-024 Position-to-score decode SHALL be a separate combinational sub-module tug_score_dec (pos, state -> score).
REQ-025 Parameter ranges SHALL be checked at elaboration, with a fatal error if out of range.

Verification (HALF=3, GAMES_TO_WIN=2, FAVOUR_LOSER=1 unless stated)
REQ-026 Reset, then 4 winrnd with right=1, leds_on=1 -> score 0001000, 0000100, 0000010, 0000001, then 0000111 with game_over=1 and right_games=1.
REQ-027 Drive pos to L3, then winrnd with right=1, leds_on=1 -> score 0010000 (L1); repeat with leds_on=0, right=0 -> score 0100000 (L2).
REQ-028 winrnd with tie=1 at N -> score stays 0001000; winrnd with right=0, leds_on=0 -> 0000100 (jumped-light left push moves right).
REQ-029 In WIN_R, assert winrnd and newgame in the same cycle -> state PLAY, score 0001000, tally unchanged.
REQ-030 Left wins two games -> score 1110000, match_over=1, left_games=2; newgame ignored; rst -> score 0001000 and both tallies 0.
REQ-031 HALF=5, FAVOUR_LOSER=0: from L5, proper right push -> L4 (score bit 9 set); 6 left moves from N -> WL, score bits 10..6 set.
